// File: rtl/dcc_pkg.sv
// Shared definitions for the dilated causal conv datapath.
// Holds the tap-buffer FSM state type, the tap count and the default
// sample width. The dot_product block and later conv layers import the
// same package so that widths and tap count stay consistent.
package dcc_pkg;

  // Tap-buffer sequencing: accept, three RAM read states, then hold until consumed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD1   = 3'd1,
    RD0   = 3'd2,
    LAST  = 3'd3,
    VALID = 3'd4
  } tb_state_e;

  localparam int NUM_TAPS = 4;
  localparam int DCC_W    = 16;

endpackage

// File: rtl/tap_ram.sv
// Sample storage for the dilated tap buffer.
// DEPTH x W memory with one synchronous write port and one synchronous
// read port (one clock of read latency). The contents have no reset.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address, sampled every clock
//   rdata_o  out  data at raddr_i from the previous clock edge
module tap_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dilated_tap_buffer.sv
// Activation cache for one dilated causal conv layer.
// Each accepted sample x[n] is stored in a circular buffer and produces one
// tap set a_d0..a_d3 = x[n-3D], x[n-2D], x[n-D], x[n]. Taps reaching back
// past the start of the stream read as zero.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   in         in   signed sample x[n]
//   in_v       in   sample valid
//   in_ready   out  high only while idle
//   a_d0..a_d3 out  signed taps, registered
//   out_v      out  tap set valid, held until out_ready
//   out_ready  in   downstream consumes the tap set
module dilated_tap_buffer
  import dcc_pkg::*;
#(
  parameter int W        = DCC_W,
  parameter int DILATION = 4,
  parameter int DEPTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in,
  input  logic                in_v,
  output logic                in_ready,
  output logic signed [W-1:0] a_d0,
  output logic signed [W-1:0] a_d1,
  output logic signed [W-1:0] a_d2,
  output logic signed [W-1:0] a_d3,
  output logic                out_v,
  input  logic                out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(3*DILATION+1);

  if ((DILATION < 1) || (DEPTH < 3*DILATION+1)) begin : g_param_check
    $error("dilated_tap_buffer: need DILATION >= 1 and DEPTH >= 3*DILATION+1");
  end

  tb_state_e state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic signed [W-1:0] taps_q [NUM_TAPS];
  logic signed [W-1:0] taps_d [NUM_TAPS];
  logic                out_v_q, out_v_d;
  logic                in_ready_q, in_ready_d;
  logic                ram_we_s;
  logic [PW-1:0]       rd_addr_s;
  logic [W-1:0]        ram_rdata_s;

  // Circular address 'back' samples behind ptr; back never exceeds DEPTH,
  // so one conditional add replaces a modulo.
  function automatic logic [PW-1:0] tap_addr(input logic [PW-1:0] ptr, input int back);
    int a_s;
    a_s = int'(ptr) - back;
    if (a_s < 0) begin
      a_s = a_s + DEPTH;
    end else begin
      a_s = a_s;
    end
    return a_s[PW-1:0];
  endfunction

  tap_ram #(
    .W    (W),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we_s),
    .waddr_i(wr_ptr_q),
    .wdata_i(in),
    .raddr_i(rd_addr_s),
    .rdata_o(ram_rdata_s)
  );

  // State and datapath registers with asynchronous abort to the empty-stream state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      taps_q     <= '{default: '0};
      out_v_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      taps_q     <= taps_d;
      out_v_q    <= out_v_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic. The read address issued in one state returns data in
  // the next, so each read state captures the tap requested one clock earlier.
  // wr_ptr and fill stay frozen until the tap set is consumed.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    taps_d     = taps_q;
    out_v_d    = out_v_q;
    in_ready_d = in_ready_q;
    ram_we_s   = 1'b0;
    rd_addr_s  = tap_addr(wr_ptr_q, DILATION);
    case (state_q)
      IDLE: begin
        if (in_v && in_ready_q) begin
          ram_we_s   = 1'b1;
          taps_d[3]  = in;
          in_ready_d = 1'b0;
          state_d    = RD1;
        end else begin
          state_d = IDLE;
        end
      end
      RD1: begin
        taps_d[2] = (fill_q >= FW'(DILATION)) ? ram_rdata_s : '0;
        rd_addr_s = tap_addr(wr_ptr_q, 2*DILATION);
        state_d   = RD0;
      end
      RD0: begin
        taps_d[1] = (fill_q >= FW'(2*DILATION)) ? ram_rdata_s : '0;
        rd_addr_s = tap_addr(wr_ptr_q, 3*DILATION);
        state_d   = LAST;
      end
      LAST: begin
        taps_d[0] = (fill_q >= FW'(3*DILATION)) ? ram_rdata_s : '0;
        out_v_d   = 1'b1;
        state_d   = VALID;
      end
      VALID: begin
        if (out_ready) begin
          out_v_d    = 1'b0;
          in_ready_d = 1'b1;
          state_d    = IDLE;
          if (wr_ptr_q == PW'(DEPTH-1)) begin
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
          if (fill_q == FW'(3*DILATION)) begin
            fill_d = fill_q;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end else begin
          state_d = VALID;
        end
      end
      default: begin
        state_d    = IDLE;
        out_v_d    = 1'b0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  assign in_ready = in_ready_q;
  assign out_v    = out_v_q;
  assign a_d0     = taps_q[0];
  assign a_d1     = taps_q[1];
  assign a_d2     = taps_q[2];
  assign a_d3     = taps_q[3];

endmodule

// File: tb/tb_dilated_tap_buffer.sv
module tb_dilated_tap_buffer;

  localparam int W = 16;
  localparam int D = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [W-1:0] in_s = '0;
  logic in_v = 1'b0;
  logic in_ready;
  logic signed [W-1:0] a_d0, a_d1, a_d2, a_d3;
  logic out_v;
  logic out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int hs_cnt = 0;
  int rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

  logic [W-1:0] hist[$];        // every sample accepted since reset
  logic [4*W-1:0] sb_q[$];      // expected tap sets {a_d0,a_d1,a_d2,a_d3}
  logic [4*W-1:0] last_taps = '0;

  dilated_tap_buffer #(.W(W), .DILATION(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in(in_s), .in_v(in_v), .in_ready(in_ready),
    .a_d0(a_d0), .a_d1(a_d1), .a_d2(a_d2), .a_d3(a_d3),
    .out_v(out_v), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference: tap k*D back is x[n-k*D] from the accepted history, 0 if before the stream.
  function automatic logic [4*W-1:0] model_taps();
    logic [4*W-1:0] e;
    int n;
    int idx;
    e = '0;
    n = hist.size() - 1;
    for (int k = 0; k < 4; k++) begin
      idx = n - k*D;
      e[k*W +: W] = (idx >= 0) ? hist[idx] : '0;
    end
    return e;
  endfunction

  // out_ready driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: log accepts into the model, compare every consumed tap set.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_v && in_ready) begin
        hist.push_back(in_s);
        sb_q.push_back(model_taps());
        acc_cnt++;
      end
      if (out_v && out_ready) begin
        last_taps = {a_d0, a_d1, a_d2, a_d3};
        hs_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got tap set %h with nothing expected", last_taps);
        end else begin
          logic [4*W-1:0] e;
          e = sb_q.pop_front();
          if (last_taps !== e) begin
            errors++;
            $display("FAIL taps: got %h required %h (handshake %0d)", last_taps, e, hs_cnt);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_v = 1'b0;
    hist.delete();
    sb_q.delete();
    acc_cnt = 0;
    hs_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check1(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Present a sample and hold it until accepted; returns at posedge+1 after the accept edge.
  task automatic send(input logic [W-1:0] v);
    bit done;
    done = 1'b0;
    in_s = v;
    in_v = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_v = 1'b0;
    in_s = '0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: sample %h not accepted, got in_ready=%b required 1", v, in_ready);
    end
  endtask

  // Wait until every accepted sample has produced its handshake.
  task automatic drain();
    for (int i = 0; i < 200 && hs_cnt != acc_cnt; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (hs_cnt != acc_cnt) begin
      errors++;
      $display("FAIL drain: got %0d handshakes required %0d", hs_cnt, acc_cnt);
    end
  endtask

  function automatic logic [4*W-1:0] pk(input int t0, input int t1, input int t2, input int t3);
    return {W'(t0), W'(t1), W'(t2), W'(t3)};
  endfunction

  initial begin
    do_reset();
    check1("reset_outputs", {a_d0, a_d1, a_d2, a_d3}, '0);
    check1("reset_ctrl", {62'd0, out_v, in_ready}, {62'd0, 1'b0, 1'b1});

    // Test 1: first sample latency and zero padding.
    send(W'(1));
    @(negedge clk);
    check1("lat_e0", {62'd0, out_v, in_ready}, {62'd0, 1'b0, 1'b0});
    @(negedge clk);
    check1("lat_e1", {63'd0, out_v}, 64'd0);
    @(negedge clk);
    check1("lat_e2", {63'd0, out_v}, 64'd0);
    @(negedge clk);
    check1("lat_e3", {62'd0, out_v, in_ready}, {62'd0, 1'b1, 1'b0});
    drain();
    check1("first_taps", last_taps, pk(0, 0, 0, 1));

    // Tests 2/3: fill-up and pointer wrap.
    for (int v = 2; v <= 20; v++) begin
      send(W'(v));
      drain();
      if (v == 5)  check1("s5",  last_taps, pk(0, 0, 1, 5));
      if (v == 9)  check1("s9",  last_taps, pk(0, 1, 5, 9));
      if (v == 13) check1("s13", last_taps, pk(1, 5, 9, 13));
      if (v == 17) check1("s17_wrap", last_taps, pk(5, 9, 13, 17));
      if (v == 20) check1("s20_wrap", last_taps, pk(8, 12, 16, 20));
    end

    // Test 4: backpressure on sample 13 while upstream toggles in_v.
    do_reset();
    for (int v = 1; v <= 12; v++) begin
      send(W'(v));
      drain();
    end
    rdy_mode = 1;
    out_ready = 1'b0;
    send(W'(13));
    for (int i = 0; i < 10 && !out_v; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      in_v = ~in_v;
      in_s = W'(200 + i);
      @(negedge clk);
      check1("bp_ctrl", {62'd0, out_v, in_ready}, {62'd0, 1'b1, 1'b0});
      check1("bp_taps", {a_d0, a_d1, a_d2, a_d3}, pk(1, 5, 9, 13));
      @(posedge clk);
      #1;
    end
    in_v = 1'b0;
    in_s = '0;
    rdy_mode = 0;
    out_ready = 1'b1;
    drain();
    check1("bp_release", last_taps, pk(1, 5, 9, 13));
    send(W'(14));
    drain();
    check1("bp_next", last_taps, pk(2, 6, 10, 14));

    // Test 5: reset while sample 10 is in RD0.
    do_reset();
    for (int v = 1; v <= 9; v++) begin
      send(W'(v));
      drain();
    end
    send(W'(10));
    @(posedge clk);
    #1;
    rst = 1'b1;
    hist.delete();
    sb_q.delete();
    acc_cnt = 0;
    hs_cnt = 0;
    #1;
    check1("abort_taps", {a_d0, a_d1, a_d2, a_d3}, '0);
    check1("abort_ctrl", {62'd0, out_v, in_ready}, {62'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check1("abort_quiet", {63'd0, out_v}, 64'd0);
    end
    @(posedge clk);
    #1;
    send(W'(42));
    drain();
    check1("after_abort", last_taps, pk(0, 0, 0, 42));

    // Test 6: random stream with random gaps and backpressure.
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(W'($urandom));
    end
    drain();
    checks++;
    if (acc_cnt != 200) begin
      errors++;
      $display("FAIL accept_count: got %0d required 200", acc_cnt);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d pending required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
